urv_decode: RTL and testbench
=============================

Name: urv_decode

Overview:
- Instruction decode stage; sits directly downstream of the fetch stage and consumes its valid/IR/PC triple.
- Registers one instruction per cycle and splits it into fields for the execute stage: register indices, sign-extended immediate, class flags and illegal flag.
- Drives synchronous register-file read addresses so operand data lines up with its own output registers.
- Detects load-use hazards against the instruction it currently holds, then stalls fetch and inserts a bubble.

Parameters:
- None. Instruction and address width are fixed at 32.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous, active-low reset
- f_valid_i  in  1  fetch output valid
- f_ir_i  in  32  fetched instruction
- f_pc_i  in  32  PC of fetched instruction
- f_stall_o  out  1  stall request to fetch; equals d_stall_i OR hazard
- d_stall_i  in  1  downstream stall; hold the decode register
- d_kill_i  in  1  flush (taken branch in execute)
- rf_rs1_o  out  5  register-file read address 1
- rf_rs2_o  out  5  register-file read address 2
- d_valid_o  out  1  decoded instruction valid
- d_pc_o  out  32  PC of decoded instruction
- d_ir_o  out  32  raw instruction
- d_opcode_o  out  5  ir[6:2]
- d_fun3_o  out  3  ir[14:12]
- d_fun7_o  out  7  ir[31:25]
- d_rs1_o  out  5  ir[19:15]
- d_rs2_o  out  5  ir[24:20]
- d_rd_o  out  5  ir[11:7]
- d_imm_o  out  32  sign-extended immediate
- d_is_load_o  out  1  load class
- d_is_store_o  out  1  store class
- d_is_branch_o  out  1  BRANCH, JAL or JALR
- d_is_mul_o  out  1  M-extension MUL (see Optional Feature)
- d_illegal_o  out  1  unrecognised encoding

Behaviour:
- Reset: asynchronous on rst_n_i low. All d_* registers clear to 0; d_valid_o=0. Deassertion takes effect on the next clk_i edge.
- Latency: one cycle, f_* to d_*.
- Recognised opcodes (ir[6:2]):
  - LUI 01101, AUIPC 00101: U immediate.
  - JAL 11011: J immediate.
  - JALR 11001, LOAD 00000, OP-IMM 00100: I immediate.
  - BRANCH 11000: B immediate.
  - STORE 01000: S immediate.
  - OP 01100: immediate 0.
  - SYSTEM 11100: I immediate.
- Immediates follow RV32I bit placement. Sign bit is always ir[31]. B and J immediates have bit 0 = 0. U immediate is ir[31:12] followed by 12 zeros.
- Illegal:
  - ir[1:0]!=2'b11, or opcode not in the list above → d_illegal_o=1; class flags 0; d_imm_o=0.
  - Fields and d_valid_o still pass through; execute traps.
- Source usage:
  - rs1 used by all recognised opcodes except LUI, AUIPC, JAL.
  - rs2 used by OP, BRANCH, STORE.
- Hazard (combinational) is high when all of the following hold:
  - d_valid_o and d_is_load_o
  - d_rd_o!=0
  - f_valid_i
  - incoming instruction uses rs1 with f_ir_i[19:15]==d_rd_o, or uses rs2 with f_ir_i[24:20]==d_rd_o
- Register update priority, per clock:
  1. d_kill_i → d_valid_o<=0, other fields unchanged. Applies even when d_stall_i=1.
  2. else d_stall_i → hold all.
  3. else hazard → d_valid_o<=0 (bubble), fields unchanged.
  4. else load fields from f_*; d_valid_o<=f_valid_i.
- After a bubble, d_valid_o=0, so the hazard self-clears; stall lasts exactly one cycle per load-use pair.
- rf_rs1_o/rf_rs2_o: when f_stall_o=1, output d_rs1_o/d_rs2_o. Otherwise output f_ir_i[19:15]/[24:20]. This keeps synchronous-RAM read data valid across stalls.
- Simultaneous kill and hazard: kill wins. f_stall_o is still asserted that cycle, since fetch is redirected anyway.

Optional Feature:
- Macro URV_DECODE_MUL_EN.
- Defined: OP with fun7=0000001 and fun3=000 → d_is_mul_o=1, legal.
- Undefined: d_is_mul_o tied 0; any OP with fun7=0000001 → d_illegal_o=1.

Test Plan:
- Reset mid-stream: drive a valid ADDI, assert rst_n_i low asynchronously between edges → d_valid_o=0 and d_imm_o=0 immediately, before the next edge.
- Immediates: f_ir_i=0xFFF00093 (addi x1,x0,-1) → d_imm_o=0xFFFFFFFF, d_rd_o=1. f_ir_i=0xFE000EE3 (beq x0,x0,-4) → d_imm_o=0xFFFFFFFC, d_is_branch_o=1.
- Load-use: lw x5,0(x1) then add x6,x5,x2 → one cycle with f_stall_o=1 and d_valid_o=0, then the add is issued. Same sequence with rd=x0 → no stall.
- Kill vs stall: hold d_stall_i=1 with a valid instruction, pulse d_kill_i → d_valid_o=0 next edge. Fields held while d_stall_i stays 1.
- Stall address hold: d_stall_i=1 while f_ir_i changes → rf_rs1_o/rf_rs2_o equal d_rs1_o/d_rs2_o.
- Illegal/MUL: f_ir_i=0x00000000 → d_illegal_o=1. f_ir_i=0x02208033 (mul x0,x1,x2) gives:
  - with URV_DECODE_MUL_EN: d_is_mul_o=1, d_illegal_o=0.
  - without: d_is_mul_o=0, d_illegal_o=1.

Source files
------------

// File: rtl/urv_decode.sv
// RV32I decode stage: registers one fetched instruction per cycle, splits it into fields, and stalls on load-use hazards.
// Optional M-extension MUL decode is enabled by defining URV_DECODE_MUL_EN.
module urv_decode (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  output logic        f_stall_o,
  input  logic        d_stall_i,
  input  logic        d_kill_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        d_valid_o,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_ir_o,
  output logic [4:0]  d_opcode_o,
  output logic [2:0]  d_fun3_o,
  output logic [6:0]  d_fun7_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [4:0]  d_rd_o,
  output logic [31:0] d_imm_o,
  output logic        d_is_load_o,
  output logic        d_is_store_o,
  output logic        d_is_branch_o,
  output logic        d_is_mul_o,
  output logic        d_illegal_o
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [4:0]  w_opc;
  logic [2:0]  w_fun3;
  logic [6:0]  w_fun7;
  logic        w_known;
  logic        w_mul_enc;
  logic        w_bad_op;
  logic        w_illegal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_mul;
  logic [31:0] w_imm;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_hazard;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_imm;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_is_branch;
  logic        r_is_mul;
  logic        r_illegal;

  assign w_opc  = f_ir_i[6:2];
  assign w_fun3 = f_ir_i[14:12];
  assign w_fun7 = f_ir_i[31:25];

  assign w_imm_i = {{21{f_ir_i[31]}}, f_ir_i[30:20]};
  assign w_imm_s = {{21{f_ir_i[31]}}, f_ir_i[30:25], f_ir_i[11:7]};
  assign w_imm_b = {{20{f_ir_i[31]}}, f_ir_i[7], f_ir_i[30:25], f_ir_i[11:8], 1'b0};
  assign w_imm_u = {f_ir_i[31:12], 12'b0};
  assign w_imm_j = {{12{f_ir_i[31]}}, f_ir_i[19:12], f_ir_i[20], f_ir_i[30:21], 1'b0};

  assign w_mul_enc = (w_opc == OPC_OP) && (w_fun7 == 7'b0000001);

`ifdef URV_DECODE_MUL_EN
  // Only plain MUL is implemented; the other M-extension encodings trap.
  assign w_bad_op = w_mul_enc && (w_fun3 != 3'b000);
`else
  assign w_bad_op = w_mul_enc;
`endif

  always_comb begin
    w_known   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_imm     = 32'd0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        w_known = 1'b1;
        w_imm   = w_imm_u;
      end
      OPC_JAL: begin
        w_known = 1'b1;
        w_imm   = w_imm_j;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        w_known   = 1'b1;
        w_use_rs1 = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_BRANCH: begin
        w_known   = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_b;
      end
      OPC_STORE: begin
        w_known   = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_s;
      end
      OPC_OP: begin
        w_known   = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_illegal   = (f_ir_i[1:0] != 2'b11) || !w_known || w_bad_op;
  assign w_is_load   = !w_illegal && (w_opc == OPC_LOAD);
  assign w_is_store  = !w_illegal && (w_opc == OPC_STORE);
  assign w_is_branch = !w_illegal &&
                       ((w_opc == OPC_BRANCH) || (w_opc == OPC_JAL) || (w_opc == OPC_JALR));
`ifdef URV_DECODE_MUL_EN
  assign w_is_mul    = !w_illegal && w_mul_enc;
`else
  assign w_is_mul    = 1'b0;
`endif

  // Load-use check compares the incoming sources against the held load's destination.
  assign w_hazard = r_valid && r_is_load && (r_ir[11:7] != 5'd0) && f_valid_i &&
                    ((w_use_rs1 && (f_ir_i[19:15] == r_ir[11:7])) ||
                     (w_use_rs2 && (f_ir_i[24:20] == r_ir[11:7])));

  assign f_stall_o = d_stall_i || w_hazard;

  // Re-present the held addresses while stalled so synchronous RAM data stays aligned.
  assign rf_rs1_o = f_stall_o ? r_ir[19:15] : f_ir_i[19:15];
  assign rf_rs2_o = f_stall_o ? r_ir[24:20] : f_ir_i[24:20];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'd0;
      r_ir        <= 32'd0;
      r_imm       <= 32'd0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_is_mul    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (d_kill_i) begin
      r_valid <= 1'b0;
    end else if (d_stall_i) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
    end else begin
      r_valid     <= f_valid_i;
      r_pc        <= f_pc_i;
      r_ir        <= f_ir_i;
      r_imm       <= w_illegal ? 32'd0 : w_imm;
      r_is_load   <= w_is_load;
      r_is_store  <= w_is_store;
      r_is_branch <= w_is_branch;
      r_is_mul    <= w_is_mul;
      r_illegal   <= w_illegal;
    end
  end

  assign d_valid_o     = r_valid;
  assign d_pc_o        = r_pc;
  assign d_ir_o        = r_ir;
  assign d_opcode_o    = r_ir[6:2];
  assign d_fun3_o      = r_ir[14:12];
  assign d_fun7_o      = r_ir[31:25];
  assign d_rs1_o       = r_ir[19:15];
  assign d_rs2_o       = r_ir[24:20];
  assign d_rd_o        = r_ir[11:7];
  assign d_imm_o       = r_imm;
  assign d_is_load_o   = r_is_load;
  assign d_is_store_o  = r_is_store;
  assign d_is_branch_o = r_is_branch;
  assign d_is_mul_o    = r_is_mul;
  assign d_illegal_o   = r_illegal;

endmodule

// File: tb/tb_urv_decode.sv
// Self-checking bench for urv_decode: table-driven decode vectors through a scoreboard queue, plus hazard/stall/kill/reset sequences.
module tb_urv_decode;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        f_valid_i = 1'b0;
  logic [31:0] f_ir_i = 32'd0;
  logic [31:0] f_pc_i = 32'd0;
  logic        f_stall_o;
  logic        d_stall_i = 1'b0;
  logic        d_kill_i = 1'b0;
  logic [4:0]  rf_rs1_o, rf_rs2_o;
  logic        d_valid_o;
  logic [31:0] d_pc_o, d_ir_o, d_imm_o;
  logic [4:0]  d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
  logic [2:0]  d_fun3_o;
  logic [6:0]  d_fun7_o;
  logic        d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o;

  urv_decode dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .f_valid_i(f_valid_i), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i),
    .f_stall_o(f_stall_o), .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
    .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_ir_o(d_ir_o),
    .d_opcode_o(d_opcode_o), .d_fun3_o(d_fun3_o), .d_fun7_o(d_fun7_o),
    .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o), .d_imm_o(d_imm_o),
    .d_is_load_o(d_is_load_o), .d_is_store_o(d_is_store_o),
    .d_is_branch_o(d_is_branch_o), .d_is_mul_o(d_is_mul_o), .d_illegal_o(d_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // flags = {load, store, branch, mul, illegal}
  typedef struct {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];
  vec_t sb_q[$];
  vec_t exp_v;
  int   n_pass = 0;
  int   n_total = 0;
  logic [4:0] mul_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
    f_valid_i = v;
    f_ir_i    = ir;
    f_pc_i    = pc;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
`ifdef URV_DECODE_MUL_EN
    mul_flags = 5'b00010;
`else
    mul_flags = 5'b00001;
`endif
    vecs[0]  = '{1'b1, 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 5'd1,  5'b00000};
    vecs[1]  = '{1'b1, 32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 5'd29, 5'b00100};
    vecs[2]  = '{1'b1, 32'h00000000, 32'h108, 32'h00000000, 5'd0,  5'b00001};
    vecs[3]  = '{1'b1, 32'h02208033, 32'h10C, 32'h00000000, 5'd0,  mul_flags};
    vecs[4]  = '{1'b1, 32'h123451B7, 32'h110, 32'h12345000, 5'd3,  5'b00000};
    vecs[5]  = '{1'b1, 32'h008000EF, 32'h114, 32'h00000008, 5'd1,  5'b00100};
    vecs[6]  = '{1'b1, 32'h0020A623, 32'h118, 32'h0000000C, 5'd12, 5'b01000};
    vecs[7]  = '{1'b1, 32'hFFC0A283, 32'h11C, 32'hFFFFFFFC, 5'd5,  5'b10000};
    vecs[8]  = '{1'b1, 32'h00001217, 32'h120, 32'h00001000, 5'd4,  5'b00000};
    vecs[9]  = '{1'b1, 32'h00008067, 32'h124, 32'h00000000, 5'd0,  5'b00100};
    vecs[10] = '{1'b1, 32'h00000011, 32'h128, 32'h00000000, 5'd0,  5'b00001};
    vecs[11] = '{1'b1, 32'h0000000F, 32'h12C, 32'h00000000, 5'd0,  5'b00001};
    vecs[12] = '{1'b0, 32'hFFF00093, 32'h130, 32'hFFFFFFFF, 5'd1,  5'b00000};
    vecs[13] = '{1'b1, 32'h00100073, 32'h134, 32'h00000001, 5'd0,  5'b00000};

    // Reset state
    #2;
    chk("reset_valid", {31'd0, d_valid_o}, 32'd0);
    chk("reset_ir", d_ir_o, 32'd0);
    chk("reset_imm", d_imm_o, 32'd0);
    #10 rst_n_i = 1'b1;
    tick();

    // Table vectors through the scoreboard, one instruction per cycle
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].ir, vecs[i].pc);
      sb_q.push_back(vecs[i]);
      tick();
      exp_v = sb_q.pop_front();
      $display("vec %0d: ir=%h pc=%h -> valid=%0b imm=%h rd=%0d flags=%b", i, exp_v.ir, exp_v.pc,
               d_valid_o, d_imm_o, d_rd_o,
               {d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o});
      chk($sformatf("vec%0d_valid", i), {31'd0, d_valid_o}, {31'd0, exp_v.valid});
      chk($sformatf("vec%0d_ir", i), d_ir_o, exp_v.ir);
      chk($sformatf("vec%0d_pc", i), d_pc_o, exp_v.pc);
      chk($sformatf("vec%0d_imm", i), d_imm_o, exp_v.imm);
      chk($sformatf("vec%0d_rd", i), {27'd0, d_rd_o}, {27'd0, exp_v.rd});
      chk($sformatf("vec%0d_flags", i),
          {27'd0, d_is_load_o, d_is_store_o, d_is_branch_o, d_is_mul_o, d_illegal_o},
          {27'd0, exp_v.flags});
    end

    // Load-use: lw x5,0(x1) then add x6,x5,x2
    drive(1'b1, 32'h0000A283, 32'h300);
    tick();
    drive(1'b1, 32'h00228333, 32'h304);
    #1;
    $display("seq load_use: stall=%0b rf_rs1=%0d", f_stall_o, rf_rs1_o);
    chk("lu_stall", {31'd0, f_stall_o}, 32'd1);
    chk("lu_rf_rs1_hold", {27'd0, rf_rs1_o}, 32'd1);
    chk("lu_rf_rs2_hold", {27'd0, rf_rs2_o}, 32'd0);
    tick();
    chk("lu_bubble_valid", {31'd0, d_valid_o}, 32'd0);
    chk("lu_bubble_ir", d_ir_o, 32'h0000A283);
    chk("lu_stall_clear", {31'd0, f_stall_o}, 32'd0);
    chk("lu_rf_rs1_new", {27'd0, rf_rs1_o}, 32'd5);
    tick();
    chk("lu_issue_valid", {31'd0, d_valid_o}, 32'd1);
    chk("lu_issue_ir", d_ir_o, 32'h00228333);
    chk("lu_issue_pc", d_pc_o, 32'h304);

    // Same pair with rd=x0: no stall
    drive(1'b1, 32'h0000A003, 32'h400);
    tick();
    drive(1'b1, 32'h00200333, 32'h404);
    #1;
    $display("seq load_x0: stall=%0b", f_stall_o);
    chk("x0_no_stall", {31'd0, f_stall_o}, 32'd0);
    tick();
    chk("x0_issue_valid", {31'd0, d_valid_o}, 32'd1);
    chk("x0_issue_ir", d_ir_o, 32'h00200333);

    // Kill beats a simultaneous hazard; stall still reported
    drive(1'b1, 32'h0000A283, 32'h500);
    tick();
    drive(1'b1, 32'h00228333, 32'h504);
    d_kill_i = 1'b1;
    #1;
    $display("seq kill_hazard: stall=%0b", f_stall_o);
    chk("kh_stall", {31'd0, f_stall_o}, 32'd1);
    tick();
    d_kill_i = 1'b0;
    chk("kh_valid", {31'd0, d_valid_o}, 32'd0);

    // Stall with address hold, then kill during stall
    drive(1'b1, 32'hFFF00093, 32'h600);
    tick();
    d_stall_i = 1'b1;
    drive(1'b1, 32'h0020A623, 32'h604);
    #1;
    $display("seq stall_kill: rf_rs1=%0d rf_rs2=%0d", rf_rs1_o, rf_rs2_o);
    chk("st_rf_rs1", {27'd0, rf_rs1_o}, 32'd0);
    chk("st_rf_rs2", {27'd0, rf_rs2_o}, 32'd31);
    tick();
    chk("st_hold_ir", d_ir_o, 32'hFFF00093);
    chk("st_hold_valid", {31'd0, d_valid_o}, 32'd1);
    d_kill_i = 1'b1;
    tick();
    d_kill_i = 1'b0;
    chk("st_kill_valid", {31'd0, d_valid_o}, 32'd0);
    chk("st_kill_ir", d_ir_o, 32'hFFF00093);
    tick();
    chk("st_after_kill_ir", d_ir_o, 32'hFFF00093);
    chk("st_after_kill_valid", {31'd0, d_valid_o}, 32'd0);
    d_stall_i = 1'b0;
    tick();
    chk("st_release_ir", d_ir_o, 32'h0020A623);
    chk("st_release_valid", {31'd0, d_valid_o}, 32'd1);

    // Asynchronous reset between edges
    drive(1'b1, 32'hFFF00093, 32'h700);
    tick();
    chk("ar_pre_imm", d_imm_o, 32'hFFFFFFFF);
    #2 rst_n_i = 1'b0;
    #1;
    $display("seq async_reset: valid=%0b imm=%h", d_valid_o, d_imm_o);
    chk("ar_valid", {31'd0, d_valid_o}, 32'd0);
    chk("ar_imm", d_imm_o, 32'd0);
    #2 rst_n_i = 1'b1;
    tick();
    chk("ar_recover_valid", {31'd0, d_valid_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
